cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of CPU and memory ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, maximum cycles to wait for mem_ack per beat.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have ports: cpu_req in 1 access valid; cpu_we in 1 store; cpu_addr in ADDR_WIDTH; cpu_wdata in DATA_WIDTH; hit in 1 tag match AND valid from the cache array.
REQ-007 SHALL have ports: stall out 1 hold CPU; mem_req out 1; mem_we out 1; mem_addr out ADDR_WIDTH; mem_wdata out DATA_WIDTH; mem_ack in 1; mem_rdata in DATA_WIDTH.
REQ-008 SHALL have ports: line_we out 1 write one cache word; line_set out 4 (addr[7:4]); line_word out 2 block offset; line_data out DATA_WIDTH; tag_we out 1 write tag {addr[31:8]} with V=1; miss_count out 16; timeout out 1 sticky error.

Function
REQ-009 SHALL implement states IDLE, REFILL, COMMIT, WRITE, ERROR.
REQ-010 IDLE, cpu_req=1, cpu_we=0, hit=1: stall=0, stay IDLE (zero-cycle hit).
REQ-011 IDLE, cpu_req=1, cpu_we=0, hit=0: stall=1 combinationally that cycle; latch cpu_addr; go REFILL; beat counter loaded per REQ-024; miss_count +1, saturating at 16'hFFFF.
REQ-012 REFILL: mem_req=1, mem_we=0, mem_addr={addr[31:4], beat, 2'b00}, held stable until mem_ack.
REQ-013 REFILL on mem_ack=1: line_we=1, line_set=addr[7:4], line_word=beat, line_data=mem_rdata same cycle; beat increments mod 4; after the 4th accepted beat go COMMIT.
REQ-014 COMMIT: tag_we=1 for exactly one cycle, stall=1, then IDLE; the CPU re-presents its request and now hits.
REQ-015 IDLE, cpu_req=1, cpu_we=1: stall=1; latch cpu_addr, cpu_wdata; go WRITE (write-through; cache array update is owned by the array, not this block).
REQ-016 WRITE: mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched data; on mem_ack go IDLE with stall=0 in the IDLE cycle.
REQ-017 stall SHALL be 1 in every state except IDLE, and in IDLE only per REQ-011/REQ-015.
REQ-018 mem_ack SHALL be ignored when mem_req=0; line_we and tag_we never both 1 in one cycle.
REQ-019 Wait counter SHALL reset on each mem_ack/new beat; reaching MEM_TIMEOUT cycles without ack SHALL go ERROR.
REQ-020 ERROR: timeout=1 sticky, stall=1, mem_req=0, no tag_we; exit only by reset.
REQ-021 cpu_req changes while stall=1 SHALL be ignored; latched address governs the whole transaction.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE, beat=0, wait counter=0, miss_count=0, timeout=0, and all outputs 0 (stall, mem_req, mem_we, line_we, tag_we, addresses, data).
REQ-023 Reset mid-REFILL SHALL abort with no tag_we; partially written line remains invalid.

Configuration
REQ-024 Macro CRITICAL_WORD_FIRST_EN defined: refill starts at beat=cpu_addr[3:2], wraps mod 4 (e.g. 2,3,0,1); undefined: always starts at beat=0 (0,1,2,3). Both SHALL fetch exactly 4 beats.

Verification
REQ-025 Read, hit=1 at addr 0x0001_0040 -> stall=0 same cycle, mem_req never asserted, miss_count unchanged.
REQ-026 Read miss addr 0x0001_0048, mem_ack every cycle, macro undefined -> mem_addr 0x0001_0040/44/48/4C, line_word 0..3, tag_we one cycle after 4th ack, stall=0 in following IDLE; miss_count=1.
REQ-027 Same miss with CRITICAL_WORD_FIRST_EN -> mem_addr order 0x0001_0048, 4C, 40, 44.
REQ-028 Store 0xDEAD_BEEF to 0x0001_0010, mem_ack after 3 wait cycles -> mem_we=1, mem_wdata stable 4 cycles, then IDLE, stall=0, no line_we/tag_we.
REQ-029 rst pulsed after 2nd refill beat -> all outputs 0 immediately, no tag_we; next miss restarts at its first beat.
REQ-030 mem_ack held 0 for MEM_TIMEOUT cycles in REFILL -> ERROR, timeout=1, mem_req=0, stall=1 until rst.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Blocking cache controller. Zero-cycle read hits, 4-beat line
//               refill on read miss, write-through stores, per-beat memory
//               timeout into a sticky error state.
//               Optional macro CRITICAL_WORD_FIRST_EN starts the refill at the
//               missed word and wraps mod 4; otherwise refill starts at word 0.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  input  logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  line_we,
  output logic [3:0]            line_set,
  output logic [1:0]            line_word,
  output logic [DATA_WIDTH-1:0] line_data,
  output logic                  tag_we,
  output logic [15:0]           miss_count,
  output logic                  timeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REFILL = 3'd1,
    COMMIT = 3'd2,
    WRITE  = 3'd3,
    ERROR  = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            beat;
  logic [1:0]            beats_done;
  logic [WAIT_W-1:0]     wait_cnt;
  logic [15:0]           miss_cnt;
  logic [1:0]            start_beat;
  logic                  miss_start;
  logic                  write_start;
  logic                  bus_active;
  logic                  wait_expired;

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_beat = cpu_addr[3:2];
`else
  assign start_beat = 2'b00;
`endif

  // Only IDLE accepts new requests, so CPU changes while stalled are ignored.
  assign miss_start   = (state == IDLE) && cpu_req && !cpu_we && !hit;
  assign write_start  = (state == IDLE) && cpu_req && cpu_we;
  assign bus_active   = (state == REFILL) || (state == WRITE);
  assign wait_expired = bus_active && !mem_ack &&
                        (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  assign miss_count = miss_cnt;
  assign timeout    = (state == ERROR);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Transaction latches, beat sequencing, wait counter and miss counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      beat       <= 2'b00;
      beats_done <= 2'b00;
      wait_cnt   <= '0;
      miss_cnt   <= 16'd0;
    end else begin
      if (miss_start || write_start) addr_q <= cpu_addr;
      if (write_start) wdata_q <= cpu_wdata;

      if (miss_start) begin
        beat       <= start_beat;
        beats_done <= 2'b00;
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end else if ((state == REFILL) && mem_ack) begin
        beat       <= beat + 2'd1;
        beats_done <= beats_done + 2'd1;
      end

      // Restarts on every accepted beat; held at the limit once expired.
      if (!bus_active || mem_ack) wait_cnt <= '0;
      else if (!wait_expired)     wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    line_we   = 1'b0;
    line_set  = 4'd0;
    line_word = 2'd0;
    line_data = '0;
    tag_we    = 1'b0;
    case (state)
      IDLE: begin
        // Reset holds stall low even if the CPU is already asking.
        if (cpu_req && !rst) begin
          if (cpu_we) begin
            stall     = 1'b1;
            state_nxt = WRITE;
          end else if (!hit) begin
            stall     = 1'b1;
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = {addr_q[ADDR_WIDTH-1:4], beat, 2'b00};
        line_set  = addr_q[7:4];
        line_word = beat;
        if (mem_ack) begin
          line_we   = 1'b1;
          line_data = mem_rdata;
          if (beats_done == 2'd3) state_nxt = COMMIT;
        end else if (wait_expired) begin
          state_nxt = ERROR;
        end
      end
      COMMIT: begin
        stall     = 1'b1;
        tag_we    = 1'b1;
        line_set  = addr_q[7:4];
        state_nxt = IDLE;
      end
      WRITE: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ack)           state_nxt = IDLE;
        else if (wait_expired) state_nxt = ERROR;
      end
      ERROR: begin
        stall = 1'b1;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_refill_ctrl
// Description : Directed self-checking bench for cache_refill_ctrl with a
//               queue of expected refill beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst, cpu_req, cpu_we, hit, mem_ack;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, mem_wdata, mem_rdata, line_data;
  logic          stall, mem_req, mem_we, line_we, tag_we, timeout;
  logic [3:0]    line_set;
  logic [1:0]    line_word;
  logic [15:0]   miss_count;

  typedef struct {
    logic [AW-1:0] addr;
    logic [1:0]    word;
    logic [DW-1:0] data;
  } beat_t;

  beat_t q[$];
  beat_t e;
  int    tests = 0;
  int    fails = 0;

  cache_refill_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .hit(hit),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .line_we(line_we), .line_set(line_set), .line_word(line_word),
    .line_data(line_data), .tag_we(tag_we), .miss_count(miss_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Queue the four beats of a refill in the order the controller must fetch them.
  task automatic push_line(input logic [AW-1:0] a, input logic [DW-1:0] seed);
    logic [1:0] b;
`ifdef CRITICAL_WORD_FIRST_EN
    b = a[3:2];
`else
    b = 2'd0;
`endif
    for (int i = 0; i < 4; i++) begin
      e.addr = {a[AW-1:4], b, 2'b00};
      e.word = b;
      e.data = seed + DW'(i);
      q.push_back(e);
      b = b + 2'd1;
    end
  endtask

  // One REFILL beat: pop the expected beat, ack it and check the line write.
  task automatic refill_beat(input string tag, input logic [3:0] set);
    @(negedge clk);
    cpu_req  = 1'b0;
    cpu_addr = 32'hFFFF_FFFC;
    e = q.pop_front();
    mem_rdata = e.data;
    mem_ack   = 1'b1;
    #1;
    chk({tag, "_req"},   mem_req,   1);
    chk({tag, "_addr"},  mem_addr,  e.addr);
    chk({tag, "_lwe"},   line_we,   1);
    chk({tag, "_word"},  line_word, e.word);
    chk({tag, "_data"},  line_data, e.data);
    chk({tag, "_set"},   line_set,  set);
    chk({tag, "_tagwe"}, tag_we,    0);
    chk({tag, "_stall"}, stall,     1);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_req"},   mem_req, 0);
    chk({tag, "_we"},    mem_we, 0);
    chk({tag, "_addr"},  mem_addr, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_lwe"},   line_we, 0);
    chk({tag, "_tagwe"}, tag_we, 0);
    chk({tag, "_miss"},  miss_count, 0);
    chk({tag, "_to"},    timeout, 0);
  endtask

  initial begin
    int reqs;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; hit = 1'b0; mem_ack = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; mem_rdata = '0;
    #1;
    all_zero("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Read hit: no stall, no memory traffic.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b1; cpu_addr = 32'h0001_0040;
    #1;
    chk("hit_stall", stall, 0);
    chk("hit_req", mem_req, 0);
    @(negedge clk);
    cpu_req = 1'b0; hit = 1'b0;
    #1;
    chk("hit_req_after", mem_req, 0);
    chk("hit_miss_cnt", miss_count, 0);

    // Read miss with memory acking every cycle.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; cpu_addr = 32'h0001_0048;
    mem_ack = 1'b1;
    push_line(32'h0001_0048, 32'hA000_0000);
    #1;
    chk("miss_stall_comb", stall, 1);
    chk("miss_req_idle", mem_req, 0);
    for (int i = 0; i < 4; i++) refill_beat($sformatf("refill%0d", i), 4'h4);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("commit_tagwe", tag_we, 1);
    chk("commit_stall", stall, 1);
    chk("commit_lwe", line_we, 0);
    chk("commit_req", mem_req, 0);
    chk("commit_set", line_set, 4'h4);
    @(negedge clk);
    #1;
    chk("post_commit_tagwe", tag_we, 0);
    chk("post_commit_stall", stall, 0);
    chk("miss_cnt_1", miss_count, 1);
    chk("sb_empty", q.size(), 0);

    // Write-through store with three wait cycles before the ack.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_0010; cpu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("st_stall_comb", stall, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_wdata = '0; cpu_addr = '0;
      mem_ack = (i == 3);
      #1;
      chk($sformatf("st%0d_req", i),   mem_req, 1);
      chk($sformatf("st%0d_we", i),    mem_we, 1);
      chk($sformatf("st%0d_addr", i),  mem_addr, 32'h0001_0010);
      chk($sformatf("st%0d_wdata", i), mem_wdata, 32'hDEAD_BEEF);
      chk($sformatf("st%0d_lwe", i),   line_we, 0);
      chk($sformatf("st%0d_tagwe", i), tag_we, 0);
      chk($sformatf("st%0d_stall", i), stall, 1);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("st_done_stall", stall, 0);
    chk("st_done_req", mem_req, 0);
    chk("st_miss_cnt", miss_count, 1);

    // Reset after the second refill beat aborts without a tag write.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; cpu_addr = 32'h0002_0004;
    push_line(32'h0002_0004, 32'hB000_0000);
    refill_beat("abort0", 4'h0);
    refill_beat("abort1", 4'h0);
    @(negedge clk);
    mem_ack = 1'b0;
    rst = 1'b1;
    #1;
    all_zero("mid_rst");
    @(negedge clk);
    #1;
    chk("mid_rst_tagwe", tag_we, 0);
    rst = 1'b0;
    q.delete();

    // Fresh miss restarts at its first beat, then memory goes silent.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; cpu_addr = 32'h0002_0004;
    push_line(32'h0002_0004, 32'hC000_0000);
    #1;
    chk("remiss_cnt_before", miss_count, 0);
    refill_beat("restart0", 4'h0);
    chk("remiss_cnt", miss_count, 1);
    reqs = 0;
    for (int i = 0; i < TO + 5; i++) begin
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      if (mem_req !== 1'b1) break;
      reqs++;
    end
    chk("to_wait_cycles", reqs, TO);
    chk("to_flag", timeout, 1);
    chk("to_req", mem_req, 0);
    chk("to_stall", stall, 1);
    chk("to_tagwe", tag_we, 0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    #1;
    chk("to_sticky", timeout, 1);
    chk("to_sticky_stall", stall, 1);
    chk("to_sticky_req", mem_req, 0);
    rst = 1'b1; mem_ack = 1'b0; cpu_req = 1'b0;
    #1;
    all_zero("to_rst");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
